sw_word_loader: RTL and testbench

//  Input-side counterpart of the seven-segment display path on the AES-GCM board top.

---
 rtl/aes_io_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 40 ++++
 rtl/sw_word_loader.sv | 109 ++++++++++
 tb/tb_sw_word_loader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/aes_io_pkg.sv
// rtl/aes_io_pkg.sv - phase encoding and chunk geometry for the switch word loader
package aes_io_pkg;

  typedef enum logic [1:0] {PH_KEY, PH_IV, PH_PT, PH_OUT} phase_e;

  localparam int CHUNK_W    = 16;
  localparam int KEY_CHUNKS = 8;
  localparam int IV_CHUNKS  = 6;
  localparam int PT_CHUNKS  = 8;

  function automatic logic [2:0] last_idx(phase_e ph);
    case (ph)
      PH_KEY:  return 3'(KEY_CHUNKS - 1);
      PH_IV:   return 3'(IV_CHUNKS - 1);
      PH_PT:   return 3'(PT_CHUNKS - 1);
      default: return 3'd0;
    endcase
  endfunction

  function automatic phase_e next_phase(phase_e ph);
    case (ph)
      PH_KEY:  return PH_IV;
      PH_IV:   return PH_PT;
      default: return PH_OUT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Counter runs only while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync    <= 2'b00;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync   <= {sync[0], i_raw};
      o_rise <= 1'b0;
      if (sync[1] == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        o_level <= sync[1];
        o_rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_word_loader.sv
// rtl/sw_word_loader.sv - assembles key, IV and plain text from switch chunks
module sw_word_loader
  import aes_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic          clk,
  input  logic          i_reset_n,
  input  logic [0:15]   i_sw,
  input  logic          i_btn_load,
  input  logic          i_btn_abort,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [0:127]  o_key,
  output logic [0:95]   o_iv,
  output logic [0:127]  o_plain_text,
  output logic [1:0]    o_phase,
  output logic [2:0]    o_chunk_idx,
  output logic [0:15]   o_echo
);

  logic [0:15] sw_s1, sw_s2;
  logic        load_level, load_p;
  logic        abort_level, abort_p;
  logic        unused_levels;
  logic        capture;
  phase_e      phase_q, phase_d;
  logic [2:0]  idx_q, idx_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_raw     (i_btn_load),
    .o_level   (load_level),
    .o_rise    (load_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_raw     (i_btn_abort),
    .o_level   (abort_level),
    .o_rise    (abort_p)
  );

  assign unused_levels = load_level ^ abort_level;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= i_sw;
      sw_s2 <= sw_s1;
    end
  end

  // Abort beats a coincident load; OUT ignores loads so the words stay frozen.
  assign capture = load_p && !abort_p && (phase_q != PH_OUT);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase_q <= PH_KEY;
      idx_q   <= 3'd0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    if (abort_p || (phase_q == PH_OUT && i_ready)) begin
      phase_d = PH_KEY;
      idx_d   = 3'd0;
    end else if (capture) begin
      if (idx_q == last_idx(phase_q)) begin
        phase_d = next_phase(phase_q);
        idx_d   = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // Chunk n lands at bit offset 16n; bit 0 is the first (most significant) chunk.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_key        <= '0;
      o_iv         <= '0;
      o_plain_text <= '0;
      o_echo       <= '0;
    end else if (capture) begin
      o_echo <= sw_s2;
      case (phase_q)
        PH_KEY:  o_key[{idx_q, 4'b0000} +: CHUNK_W]        <= sw_s2;
        PH_IV:   o_iv[{idx_q, 4'b0000} +: CHUNK_W]         <= sw_s2;
        PH_PT:   o_plain_text[{idx_q, 4'b0000} +: CHUNK_W] <= sw_s2;
        default: ;
      endcase
    end
  end

  assign o_valid     = (phase_q == PH_OUT);
  assign o_phase     = phase_q;
  assign o_chunk_idx = idx_q;

endmodule

// File: tb/tb_sw_word_loader.sv
// tb/tb_sw_word_loader.sv - directed, table-driven bench for sw_word_loader
module tb_sw_word_loader;

  logic         clk = 1'b0;
  logic         i_reset_n;
  logic [0:15]  i_sw;
  logic         i_btn_load;
  logic         i_btn_abort;
  logic         i_ready;
  logic         o_valid;
  logic [0:127] o_key;
  logic [0:95]  o_iv;
  logic [0:127] o_plain_text;
  logic [1:0]   o_phase;
  logic [2:0]   o_chunk_idx;
  logic [0:15]  o_echo;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] sw;
    logic [1:0]  ph;
    logic [2:0]  idx;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  sw_word_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .i_reset_n    (i_reset_n),
    .i_sw         (i_sw),
    .i_btn_load   (i_btn_load),
    .i_btn_abort  (i_btn_abort),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_key        (o_key),
    .o_iv         (o_iv),
    .o_plain_text (o_plain_text),
    .o_phase      (o_phase),
    .o_chunk_idx  (o_chunk_idx),
    .o_echo       (o_echo)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] sw, input int hold);
    i_sw = sw;
    cycles(3);
    i_btn_load = 1'b1;
    cycles(hold);
    i_btn_load = 1'b0;
    cycles(10);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 128'(o_valid), 128'd0);
    chk({tag, "_key"}, o_key, 128'd0);
    chk({tag, "_iv"}, 128'(o_iv), 128'd0);
    chk({tag, "_pt"}, o_plain_text, 128'd0);
    chk({tag, "_phase"}, 128'(o_phase), 128'd0);
    chk({tag, "_idx"}, 128'(o_chunk_idx), 128'd0);
    chk({tag, "_echo"}, 128'(o_echo), 128'd0);
  endtask

  initial begin
    for (int i = 0; i < 22; i++) begin
      int n;
      n = i + 1;
      tbl[i].sw = 16'(n);
      if (n < 8)       begin tbl[i].ph = 2'd0; tbl[i].idx = 3'(n);      end
      else if (n < 14) begin tbl[i].ph = 2'd1; tbl[i].idx = 3'(n - 8);  end
      else if (n < 22) begin tbl[i].ph = 2'd2; tbl[i].idx = 3'(n - 14); end
      else             begin tbl[i].ph = 2'd3; tbl[i].idx = 3'd0;       end
    end

    i_reset_n = 1'b0; i_sw = '0; i_btn_load = 1'b0; i_btn_abort = 1'b0; i_ready = 1'b0;
    cycles(3);
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    cycles(20);
    chk_all_zero("idle");

    // Short bounces must not reach the debounced level
    i_sw = 16'hBEEF;
    i_btn_load = 1'b1; cycles(1); i_btn_load = 1'b0; cycles(6);
    i_btn_load = 1'b1; cycles(2); i_btn_load = 1'b0; cycles(6);
    i_btn_load = 1'b1; cycles(3); i_btn_load = 1'b0; cycles(8);
    chk("bounce_echo", 128'(o_echo), 128'd0);
    chk("bounce_idx", 128'(o_chunk_idx), 128'd0);

    press(16'hBEEF, 30);
    chk("beef_echo", 128'(o_echo), 128'hBEEF);
    chk("beef_idx", 128'(o_chunk_idx), 128'd1);
    chk("beef_key0", 128'(o_key[0:15]), 128'hBEEF);
    chk("beef_phase", 128'(o_phase), 128'd0);

    i_reset_n = 1'b0; cycles(2); i_reset_n = 1'b1; cycles(2);

    for (int i = 0; i < 22; i++) begin
      press(tbl[i].sw, 10);
      chk($sformatf("load%0d_phase", i + 1), 128'(o_phase), 128'(tbl[i].ph));
      chk($sformatf("load%0d_idx", i + 1), 128'(o_chunk_idx), 128'(tbl[i].idx));
      chk($sformatf("load%0d_echo", i + 1), 128'(o_echo), 128'(tbl[i].sw));
    end
    chk("full_key", o_key, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    chk("full_iv", 128'(o_iv), 128'(96'h0009_000A_000B_000C_000D_000E));
    chk("full_pt", o_plain_text, 128'h000F_0010_0011_0012_0013_0014_0015_0016);
    chk("full_valid", 128'(o_valid), 128'd1);

    cycles(10);
    press(16'hFFFF, 10);
    chk("hold_valid", 128'(o_valid), 128'd1);
    chk("hold_phase", 128'(o_phase), 128'd3);
    chk("hold_echo", 128'(o_echo), 128'h0016);
    chk("hold_key", o_key, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    chk("hold_pt", o_plain_text, 128'h000F_0010_0011_0012_0013_0014_0015_0016);
    i_ready = 1'b1;
    cycles(1);
    i_ready = 1'b0;
    chk("hs_valid", 128'(o_valid), 128'd0);
    chk("hs_phase", 128'(o_phase), 128'd0);
    chk("hs_idx", 128'(o_chunk_idx), 128'd0);
    chk("hs_key", o_key, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    for (int k = 1; k <= 10; k++) press(16'h0100 + 16'(k), 10);
    chk("pre_abort_phase", 128'(o_phase), 128'd1);
    chk("pre_abort_idx", 128'(o_chunk_idx), 128'd2);
    i_btn_abort = 1'b1; cycles(10); i_btn_abort = 1'b0; cycles(10);
    chk("abort_phase", 128'(o_phase), 128'd0);
    chk("abort_idx", 128'(o_chunk_idx), 128'd0);
    chk("abort_valid", 128'(o_valid), 128'd0);
    chk("abort_echo", 128'(o_echo), 128'h010A);
    chk("abort_iv0", 128'(o_iv[0:15]), 128'h0109);

    i_sw = 16'h5555;
    cycles(3);
    i_btn_load = 1'b1; i_btn_abort = 1'b1;
    cycles(10);
    i_btn_load = 1'b0; i_btn_abort = 1'b0;
    cycles(10);
    chk("coinc_echo", 128'(o_echo), 128'h010A);
    chk("coinc_idx", 128'(o_chunk_idx), 128'd0);
    chk("coinc_phase", 128'(o_phase), 128'd0);
    chk("coinc_key0", 128'(o_key[0:15]), 128'h0101);

    for (int k = 1; k <= 18; k++) press(16'h0200 + 16'(k), 10);
    chk("midpt_phase", 128'(o_phase), 128'd2);
    chk("midpt_idx", 128'(o_chunk_idx), 128'd4);
    @(posedge clk);
    #2 i_reset_n = 1'b0;
    #1 chk_all_zero("async_rst");
    cycles(3);
    i_reset_n = 1'b1;
    cycles(2);

    for (int k = 1; k <= 22; k++) press(16'h3000 + 16'(k), 10);
    chk("reload_key", o_key, 128'h3001_3002_3003_3004_3005_3006_3007_3008);
    chk("reload_iv", 128'(o_iv), 128'(96'h3009_300A_300B_300C_300D_300E));
    chk("reload_pt", o_plain_text, 128'h300F_3010_3011_3012_3013_3014_3015_3016);
    chk("reload_valid", 128'(o_valid), 128'd1);
    chk("reload_phase", 128'(o_phase), 128'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
